// File: rtl/mem_pkg.sv
// Shared types and constants for the packet-buffer SRAM arbiter.
// Holds block geometry, the read-return tag and the class-alternation helper.
package mem_pkg;

  localparam int ADDR_W     = 10;
  localparam int BLOCK_BITS = 32;
  localparam int RD_ID_W    = 4;

  typedef enum logic {
    CLS_WR = 1'b0,
    CLS_RD = 1'b1
  } cls_t;

  typedef struct packed {
    logic               valid;
    logic [RD_ID_W-1:0] id;
  } rd_tag_t;

  // With both classes pending, the class not granted last time wins.
  function automatic logic pick_write(input logic wr_any, input logic rd_any, input cls_t last_cls);
    if (wr_any && rd_any) begin
      return (last_cls == CLS_RD);
    end else begin
      return wr_any;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester at or after the pointer
// when enabled, and advances the pointer past the winner on a grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] win;
  logic [PW-1:0] idx_p;
  logic          found;
  logic [N-1:0]  one_hot;
  int            idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    idx_p = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      idx_p = PW'(idx);
      if (!found && req[idx_p]) begin
        found = 1'b1;
        win   = idx_p;
      end else begin
        found = found;
      end
    end
  end

  always_comb begin
    one_hot      = '0;
    one_hot[win] = 1'b1;
    ptr_nxt      = (win == PW'(N - 1)) ? '0 : win + 1'b1;
  end

  assign gnt = (en && found) ? one_hot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates write and read controllers onto one single-port SRAM and routes
// read data back in order. Optional grant/stall counters under MEM_ARB_STATS_EN.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_WR     = 4,
  parameter int NUM_RD     = 4,
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS,
  parameter int RD_LAT     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WR-1:0]            wr_req_i,
  input  logic [NUM_WR*ADDR_W-1:0]     wr_addr_i,
  input  logic [NUM_WR*BLOCK_BITS-1:0] wr_data_i,
  output logic [NUM_WR-1:0]            wr_gnt_o,
  input  logic [NUM_RD-1:0]            rd_req_i,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr_i,
  output logic [NUM_RD-1:0]            rd_gnt_o,
  output logic [NUM_RD-1:0]            rd_valid_o,
  output logic [BLOCK_BITS-1:0]        rd_data_o,
  input  logic                         mem_ready_i,
  output logic                         mem_en_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [BLOCK_BITS-1:0]        mem_wdata_o,
  input  logic [BLOCK_BITS-1:0]        mem_rdata_i
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic                         stats_clr_i,
  output logic [31:0]                  wr_grants_o,
  output logic [31:0]                  rd_grants_o,
  output logic [31:0]                  stall_cycles_o
`endif
);

  logic                  wr_any;
  logic                  rd_any;
  logic                  sel_wr;
  logic                  wr_en;
  logic                  rd_en;
  cls_t                  last_cls;
  cls_t                  last_cls_nxt;
  logic [ADDR_W-1:0]     wsel_addr;
  logic [BLOCK_BITS-1:0] wsel_data;
  logic [ADDR_W-1:0]     rsel_addr;
  logic [RD_ID_W-1:0]    rsel_id;
  logic [RD_ID_W-1:0]    cmd_id;
  rd_tag_t               pipe [RD_LAT];
  rd_tag_t               tail;

  assign wr_any = |wr_req_i;
  assign rd_any = |rd_req_i;
  assign sel_wr = pick_write(wr_any, rd_any, last_cls);
  assign wr_en  = mem_ready_i && wr_any && sel_wr;
  assign rd_en  = mem_ready_i && rd_any && !sel_wr;

  rr_arbiter #(.N(NUM_WR)) u_wr_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req_i),
    .en    (wr_en),
    .gnt   (wr_gnt_o)
  );

  rr_arbiter #(.N(NUM_RD)) u_rd_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req_i),
    .en    (rd_en),
    .gnt   (rd_gnt_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cls <= CLS_RD;
    end else begin
      last_cls <= last_cls_nxt;
    end
  end

  always_comb begin
    last_cls_nxt = last_cls;
    if (|wr_gnt_o) begin
      last_cls_nxt = CLS_WR;
    end else if (|rd_gnt_o) begin
      last_cls_nxt = CLS_RD;
    end else begin
      last_cls_nxt = last_cls;
    end
  end

  // Grants are one-hot, so an AND-OR mux yields zero when nothing is granted.
  always_comb begin
    wsel_addr = '0;
    wsel_data = '0;
    rsel_addr = '0;
    rsel_id   = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      wsel_addr = wsel_addr | (wr_addr_i[i*ADDR_W +: ADDR_W] & {ADDR_W{wr_gnt_o[i]}});
      wsel_data = wsel_data | (wr_data_i[i*BLOCK_BITS +: BLOCK_BITS] & {BLOCK_BITS{wr_gnt_o[i]}});
    end
    for (int i = 0; i < NUM_RD; i++) begin
      rsel_addr = rsel_addr | (rd_addr_i[i*ADDR_W +: ADDR_W] & {ADDR_W{rd_gnt_o[i]}});
      rsel_id   = rsel_id | (RD_ID_W'(i) & {RD_ID_W{rd_gnt_o[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cmd_id      <= '0;
    end else begin
      mem_en_o    <= (|wr_gnt_o) | (|rd_gnt_o);
      mem_we_o    <= |wr_gnt_o;
      mem_addr_o  <= wsel_addr | rsel_addr;
      mem_wdata_o <= wsel_data;
      cmd_id      <= rsel_id;
    end
  end

  // Tag pipeline is loaded on the command cycle so its tail lines up with rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipe[s] <= '0;
      end
    end else begin
      pipe[0] <= {mem_en_o & ~mem_we_o, cmd_id};
      for (int s = 1; s < RD_LAT; s++) begin
        pipe[s] <= pipe[s-1];
      end
    end
  end

  assign tail = pipe[RD_LAT-1];

  always_comb begin
    rd_valid_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_valid_o[i] = tail.valid && (tail.id == RD_ID_W'(i));
    end
    rd_data_o = tail.valid ? mem_rdata_i : '0;
  end

`ifdef MEM_ARB_STATS_EN
  logic pending;
  assign pending = wr_any | rd_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_grants_o    <= 32'd0;
      rd_grants_o    <= 32'd0;
      stall_cycles_o <= 32'd0;
    end else if (stats_clr_i) begin
      wr_grants_o    <= 32'd0;
      rd_grants_o    <= 32'd0;
      stall_cycles_o <= 32'd0;
    end else begin
      if ((|wr_gnt_o) && (wr_grants_o != 32'hFFFF_FFFF)) wr_grants_o <= wr_grants_o + 32'd1;
      if ((|rd_gnt_o) && (rd_grants_o != 32'hFFFF_FFFF)) rd_grants_o <= rd_grants_o + 32'd1;
      if (pending && !mem_ready_i && (stall_cycles_o != 32'hFFFF_FFFF)) stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int NW = 4;
  localparam int NR = 4;
  localparam int AW = mem_pkg::ADDR_W;
  localparam int BB = mem_pkg::BLOCK_BITS;
  localparam int RL = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NW-1:0]     wr_req;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*BB-1:0]  wr_data;
  logic [NW-1:0]     wr_gnt;
  logic [NR-1:0]     rd_req;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR-1:0]     rd_gnt;
  logic [NR-1:0]     rd_valid;
  logic [BB-1:0]     rd_data;
  logic              mem_ready;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [BB-1:0]     mem_wdata;
  logic [BB-1:0]     mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic              stats_clr;
  logic [31:0]       wr_grants;
  logic [31:0]       rd_grants;
  logic [31:0]       stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .NUM_WR(NW), .NUM_RD(NR), .ADDR_W(AW), .BLOCK_BITS(BB), .RD_LAT(RL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req_i    (wr_req),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_gnt_o    (wr_gnt),
    .rd_req_i    (rd_req),
    .rd_addr_i   (rd_addr),
    .rd_gnt_o    (rd_gnt),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data),
    .mem_ready_i (mem_ready),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stats_clr_i    (stats_clr),
    .wr_grants_o    (wr_grants),
    .rd_grants_o    (rd_grants),
    .stall_cycles_o (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".wr_gnt"},    64'(wr_gnt),    64'd0);
    check({tag, ".rd_gnt"},    64'(rd_gnt),    64'd0);
    check({tag, ".rd_valid"},  64'(rd_valid),  64'd0);
    check({tag, ".rd_data"},   64'(rd_data),   64'd0);
    check({tag, ".mem_en"},    64'(mem_en),    64'd0);
    check({tag, ".mem_we"},    64'(mem_we),    64'd0);
    check({tag, ".mem_addr"},  64'(mem_addr),  64'd0);
    check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  initial begin
    int p;
    int widx;
    logic [NR-1:0] exp_v;

    wr_req    = '0;
    rd_req    = '0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr   = '0;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_0001;
`ifdef MEM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif

    repeat (2) @(negedge clk);
    #1 check_idle("reset");
    rst_n = 1'b1;

    // Single write from requester 2
    @(negedge clk);
    wr_addr[2*AW +: AW] = 10'h015;
    wr_data[2*BB +: BB] = 32'hD00D_0002;
    wr_req = 4'b0100;
    #1 check("wr1.gnt", 64'(wr_gnt), 64'h4);
    check("wr1.rd_gnt", 64'(rd_gnt), 64'h0);
    @(negedge clk);
    wr_req = 4'b0000;
    #1 check("wr1.en", 64'(mem_en), 64'h1);
    check("wr1.we", 64'(mem_we), 64'h1);
    check("wr1.addr", 64'(mem_addr), 64'h15);
    check("wr1.wdata", 64'(mem_wdata), 64'hD00D_0002);
    @(negedge clk);
    #1 check("wr1.en_off", 64'(mem_en), 64'h0);
    check("wr1.addr_off", 64'(mem_addr), 64'h0);

    // Single read from requester 1, returned RD_LAT cycles after the command
    @(negedge clk);
    rd_addr[1*AW +: AW] = 10'h007;
    rd_req = 4'b0010;
    #1 check("rd1.gnt", 64'(rd_gnt), 64'h2);
    @(negedge clk);
    rd_req = 4'b0000;
    #1 check("rd1.en", 64'(mem_en), 64'h1);
    check("rd1.we", 64'(mem_we), 64'h0);
    check("rd1.addr", 64'(mem_addr), 64'h7);
    check("rd1.valid_t1", 64'(rd_valid), 64'h0);
    @(negedge clk);
    #1 check("rd1.valid_t2", 64'(rd_valid), 64'h0);
    @(negedge clk);
    #1 check("rd1.valid_t3", 64'(rd_valid), 64'h2);
    check("rd1.data_t3", 64'(rd_data), 64'hCAFE_0001);
    @(negedge clk);
    #1 check("rd1.valid_t4", 64'(rd_valid), 64'h0);
    check("rd1.data_t4", 64'(rd_data), 64'h0);

    // Wrap-around: write pointer sits at 3
    @(negedge clk);
    wr_req = 4'b1010;
    #1 check("wrap.g3", 64'(wr_gnt), 64'h8);
    @(negedge clk);
    wr_req = 4'b0010;
    #1 check("wrap.g1", 64'(wr_gnt), 64'h2);
    @(negedge clk);
    wr_req = 4'b1110;
    #1 check("wrap.ptr2", 64'(wr_gnt), 64'h4);
    @(negedge clk);
    wr_req = 4'b0000;

    // Backpressure: five stalled cycles, then read class wins at rd pointer 2
    @(negedge clk);
    mem_ready = 1'b0;
    wr_req = 4'hF;
    rd_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1 check("bp.wr_gnt", 64'(wr_gnt), 64'h0);
      check("bp.rd_gnt", 64'(rd_gnt), 64'h0);
      check("bp.mem_en", 64'(mem_en), 64'h0);
      @(negedge clk);
    end
`ifdef MEM_ARB_STATS_EN
    check("stats.stall", 64'(stall_cycles), 64'd5);
    check("stats.wr", 64'(wr_grants), 64'd4);
    check("stats.rd", 64'(rd_grants), 64'd1);
`endif
    mem_ready = 1'b1;
    #1 check("bp.rel_rd", 64'(rd_gnt), 64'h4);
    check("bp.rel_wr", 64'(wr_gnt), 64'h0);
    @(negedge clk);
    wr_req = 4'h0;
    rd_req = 4'h0;
    #1 check("bp.cmd_en", 64'(mem_en), 64'h1);
    check("bp.cmd_we", 64'(mem_we), 64'h0);

    // Reset one cycle after the read command: the pending return must vanish
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_idle("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 check("midrst.no_valid", 64'(rd_valid), 64'h0);
      @(negedge clk);
    end
`ifdef MEM_ARB_STATS_EN
    check("stats.rst", 64'(wr_grants), 64'd0);
`endif

    // Full contention from fresh pointers: W0,R0,W1,R1,...
    for (int i = 0; i < NW; i++) begin
      wr_addr[i*AW +: AW] = AW'(32'h10 + i);
      wr_data[i*BB +: BB] = BB'(32'hD0 + i);
    end
    for (int i = 0; i < NR; i++) begin
      rd_addr[i*AW +: AW] = AW'(32'h20 + i);
    end
    wr_req = 4'hF;
    rd_req = 4'hF;
    for (int k = 0; k < 20; k++) begin
      widx = (k / 2) % 4;
      #1;
      if (k % 2 == 0) begin
        check("cont.wr_gnt", 64'(wr_gnt), 64'(4'b0001 << widx));
        check("cont.rd_gnt", 64'(rd_gnt), 64'h0);
      end else begin
        check("cont.wr_gnt", 64'(wr_gnt), 64'h0);
        check("cont.rd_gnt", 64'(rd_gnt), 64'(4'b0001 << widx));
      end
      if (k >= 1) begin
        p = k - 1;
        check("cont.mem_en", 64'(mem_en), 64'h1);
        if (p % 2 == 0) begin
          check("cont.we", 64'(mem_we), 64'h1);
          check("cont.addr", 64'(mem_addr), 64'(32'h10 + (p / 2) % 4));
          check("cont.wdata", 64'(mem_wdata), 64'(32'hD0 + (p / 2) % 4));
        end else begin
          check("cont.we", 64'(mem_we), 64'h0);
          check("cont.addr", 64'(mem_addr), 64'(32'h20 + (p / 2) % 4));
        end
      end
      if (k >= 3) begin
        p = k - 3;
        exp_v = (p % 2 == 1) ? (4'b0001 << ((p / 2) % 4)) : 4'b0000;
        check("cont.rd_valid", 64'(rd_valid), 64'(exp_v));
      end
      @(negedge clk);
    end
    wr_req = 4'h0;
    rd_req = 4'h0;

`ifdef MEM_ARB_STATS_EN
    #1 check("stats.cont_wr", 64'(wr_grants), 64'd10);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #1 check("stats.clr", 64'(wr_grants), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
